// File: rtl/demux_pkg.sv
// Shared constants and helpers for the registered 1x2 demultiplexer.
// Stats counters are only instantiated when DEMUX_STATS_EN is defined.
package demux_pkg;

   localparam int DEMUX_N_DEFAULT = 32;
   localparam int STATS_W         = 16;

   typedef enum logic {
      DEST_A = 1'b0,
      DEST_B = 1'b1
   } dest_e;

   // Saturating increment: sticks at all-ones instead of wrapping.
   function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
      return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/nbit_demux_1x2_reg_if.sv
// Handshake bundle for nbit_demux_1x2_reg: one upstream channel, two destinations.
// slave = demux view, master = environment view.
interface nbit_demux_1x2_reg_if
   import demux_pkg::*;
#(
   parameter int N = DEMUX_N_DEFAULT
);
   logic         in_valid;
   logic         in_ready;
   logic         in_sel;
   logic [N-1:0] in_data;

   logic         a_valid;
   logic         a_ready;
   logic [N-1:0] a_data;

   logic         b_valid;
   logic         b_ready;
   logic [N-1:0] b_data;

   modport slave (
      input  in_valid, in_sel, in_data, a_ready, b_ready,
      output in_ready, a_valid, a_data, b_valid, b_data
   );

   modport master (
      output in_valid, in_sel, in_data, a_ready, b_ready,
      input  in_ready, a_valid, a_data, b_valid, b_data
   );
endinterface

// File: rtl/demux_slot.sv
// Single-entry register slot: full flag plus data register with
// same-cycle drain-and-refill.
module demux_slot
   import demux_pkg::*;
#(
   parameter int N = DEMUX_N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [N-1:0] i_data,
   input  logic         i_ready,
   output logic         o_full,
   output logic [N-1:0] o_data,
   output logic         o_can_load,
   output logic         o_drain
);

   logic         r_full;
   logic [N-1:0] r_data;

   assign o_drain    = r_full & i_ready;
   assign o_can_load = ~r_full | i_ready;

   // A load that coincides with a drain keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
         r_data <= '0;
      end else begin
         if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
         end else if (o_drain) begin
            r_full <= 1'b0;
         end
      end
   end

   assign o_full = r_full;
   assign o_data = r_data;

endmodule

// File: rtl/nbit_demux_1x2_reg.sv
// Registered 1x2 demultiplexer with per-destination single-entry slots.
// Optional transfer counters enabled by macro DEMUX_STATS_EN.
module nbit_demux_1x2_reg
   import demux_pkg::*;
#(
   parameter int N = DEMUX_N_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   nbit_demux_1x2_reg_if.slave       ifc
`ifdef DEMUX_STATS_EN
   ,
   output logic [STATS_W-1:0]        a_count,
   output logic [STATS_W-1:0]        b_count
`endif
);

   dest_e        w_dest;
   logic         w_a_can_load;
   logic         w_b_can_load;
   logic         w_a_load;
   logic         w_b_load;
   logic         w_a_drain;
   logic         w_b_drain;
   logic         w_a_full;
   logic         w_b_full;
   logic [N-1:0] w_a_data;
   logic [N-1:0] w_b_data;

   assign w_dest = dest_e'(ifc.in_sel);

   // in_ready looks only at the selected slot, never at in_valid.
   assign ifc.in_ready = (w_dest == DEST_B) ? w_b_can_load : w_a_can_load;

   assign w_a_load = ifc.in_valid & (w_dest == DEST_A) & w_a_can_load;
   assign w_b_load = ifc.in_valid & (w_dest == DEST_B) & w_b_can_load;

   demux_slot #(.N(N)) u_slot_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_a_load),
      .i_data     (ifc.in_data),
      .i_ready    (ifc.a_ready),
      .o_full     (w_a_full),
      .o_data     (w_a_data),
      .o_can_load (w_a_can_load),
      .o_drain    (w_a_drain)
   );

   demux_slot #(.N(N)) u_slot_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_b_load),
      .i_data     (ifc.in_data),
      .i_ready    (ifc.b_ready),
      .o_full     (w_b_full),
      .o_data     (w_b_data),
      .o_can_load (w_b_can_load),
      .o_drain    (w_b_drain)
   );

   assign ifc.a_valid = w_a_full;
   assign ifc.a_data  = w_a_data;
   assign ifc.b_valid = w_b_full;
   assign ifc.b_data  = w_b_data;

`ifdef DEMUX_STATS_EN
   logic [STATS_W-1:0] r_a_count;
   logic [STATS_W-1:0] r_b_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_count <= '0;
         r_b_count <= '0;
      end else begin
         if (w_a_drain) r_a_count <= sat_inc(r_a_count);
         if (w_b_drain) r_b_count <= sat_inc(r_b_count);
      end
   end

   assign a_count = r_a_count;
   assign b_count = r_b_count;
`endif

endmodule
